// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port single-memory arbiter, 1-cycle response pipeline
// MEM_ARB_FIXED_PRIO_EN selects fixed port-1 priority instead of round-robin.
module mem_arbiter #(
  parameter int BUSWIDTH  = 32,
  parameter int ADDRWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req_valid,
  input  logic                 p0_req_we,
  input  logic [ADDRWIDTH-1:0] p0_req_addr,
  input  logic [BUSWIDTH-1:0]  p0_req_wdata,
  output logic                 p0_req_ready,
  output logic                 p0_resp_valid,
  output logic [BUSWIDTH-1:0]  p0_resp_rdata,
  input  logic                 p1_req_valid,
  input  logic                 p1_req_we,
  input  logic [ADDRWIDTH-1:0] p1_req_addr,
  input  logic [BUSWIDTH-1:0]  p1_req_wdata,
  output logic                 p1_req_ready,
  output logic                 p1_resp_valid,
  output logic [BUSWIDTH-1:0]  p1_resp_rdata,
  output logic [ADDRWIDTH-1:0] mem_rd_addr,
  output logic [ADDRWIDTH-1:0] mem_wr_addr,
  output logic [BUSWIDTH-1:0]  mem_wr_data,
  output logic                 mem_wren,
  input  logic [BUSWIDTH-1:0]  mem_rd_data,
  output logic                 busy
);

  logic                 grant0, grant1, any_grant;
  logic                 gnt_we;
  logic [ADDRWIDTH-1:0] gnt_addr;
  logic [BUSWIDTH-1:0]  gnt_wdata;
  logic                 resp_owner_vld_q, resp_owner_vld_d;
  logic                 resp_owner_q, resp_owner_d;
  logic                 resp_is_wr_q, resp_is_wr_d;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic rr_last_q, rr_last_d;
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (p0_req_valid && p1_req_valid) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        grant1 = 1'b1;
`else
        // rr_last names the port served most recently; the other one wins
        grant0 = rr_last_q;
        grant1 = !rr_last_q;
`endif
      end else begin
        grant0 = p0_req_valid;
        grant1 = p1_req_valid;
      end
    end
    any_grant = grant0 || grant1;
  end

  always_comb begin
    gnt_we    = grant1 ? p1_req_we    : p0_req_we;
    gnt_addr  = grant1 ? p1_req_addr  : p0_req_addr;
    gnt_wdata = grant1 ? p1_req_wdata : p0_req_wdata;

    p0_req_ready = grant0;
    p1_req_ready = grant1;
    mem_rd_addr  = '0;
    mem_wr_addr  = '0;
    mem_wr_data  = '0;
    mem_wren     = 1'b0;
    if (any_grant) begin
      if (gnt_we) begin
        mem_wr_addr = gnt_addr;
        mem_wr_data = gnt_wdata;
        mem_wren    = 1'b1;
      end else begin
        mem_rd_addr = gnt_addr;
      end
    end

    resp_owner_vld_d = any_grant;
    resp_owner_d     = any_grant ? grant1 : resp_owner_q;
    resp_is_wr_d     = any_grant ? gnt_we : resp_is_wr_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    rr_last_d        = any_grant ? grant1 : rr_last_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_owner_vld_q <= 1'b0;
      resp_owner_q     <= 1'b0;
      resp_is_wr_q     <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_last_q        <= 1'b1;
`endif
    end else begin
      resp_owner_vld_q <= resp_owner_vld_d;
      resp_owner_q     <= resp_owner_d;
      resp_is_wr_q     <= resp_is_wr_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
      rr_last_q        <= rr_last_d;
`endif
    end
  end

  // Write acknowledges carry zero data; only the read owner sees mem_rd_data
  always_comb begin
    p0_resp_valid = resp_owner_vld_q && !resp_owner_q;
    p1_resp_valid = resp_owner_vld_q && resp_owner_q;
    p0_resp_rdata = (p0_resp_valid && !resp_is_wr_q) ? mem_rd_data : '0;
    p1_resp_rdata = (p1_resp_valid && !resp_is_wr_q) ? mem_rd_data : '0;
    busy          = resp_owner_vld_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
// Expectations for the conflict test follow MEM_ARB_FIXED_PRIO_EN when defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req_valid, p0_req_we, p0_req_ready, p0_resp_valid;
  logic [31:0] p0_req_addr, p0_req_wdata, p0_resp_rdata;
  logic        p1_req_valid, p1_req_we, p1_req_ready, p1_resp_valid;
  logic [31:0] p1_req_addr, p1_req_wdata, p1_resp_rdata;
  logic [31:0] mem_rd_addr, mem_wr_addr, mem_wr_data, mem_rd_data;
  logic        mem_wren, busy;

  logic [31:0] mem [0:255];
  bit          mem_loaded = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_port [4];

  mem_arbiter #(.BUSWIDTH(32), .ADDRWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_req_ready(p0_req_ready),
    .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_req_ready(p1_req_ready),
    .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wren(mem_wren), .mem_rd_data(mem_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after the address is sampled
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEAD_BEEF;
      mem_loaded <= 1'b1;
    end else if (mem_wren) begin
      mem[mem_wr_addr[7:0]] <= mem_wr_data;
    end
    mem_rd_data <= mem[mem_rd_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = '0; p0_req_wdata = '0;
    p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = '0; p1_req_wdata = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    check("rst_p0_resp_valid", {31'b0, p0_resp_valid}, 32'd0);
    check("rst_p1_resp_valid", {31'b0, p1_resp_valid}, 32'd0);
    check("rst_busy",          {31'b0, busy},          32'd0);
    check("rst_ready",         {30'b0, p1_req_ready, p0_req_ready}, 32'd0);
    check("rst_wren",          {31'b0, mem_wren},      32'd0);
    rst = 1'b0;

    // p0 read of 0x10
    p0_req_valid = 1'b1; p0_req_addr = 32'h10;
    #1;
    check("rd_p0_ready",   {31'b0, p0_req_ready}, 32'd1);
    check("rd_mem_rd_addr", mem_rd_addr, 32'h10);
    check("rd_mem_wren",   {31'b0, mem_wren}, 32'd0);
    tick();
    p0_req_valid = 1'b0;
    #1;
    check("rd_p0_resp_valid", {31'b0, p0_resp_valid}, 32'd1);
    check("rd_p0_resp_rdata", p0_resp_rdata, 32'hDEAD_BEEF);
    check("rd_p1_resp_valid", {31'b0, p1_resp_valid}, 32'd0);
    check("rd_busy",          {31'b0, busy}, 32'd1);

    // p1 write of 0x20, then p0 read of 0x20 on the very next cycle
    p1_req_valid = 1'b1; p1_req_we = 1'b1; p1_req_addr = 32'h20; p1_req_wdata = 32'h1234_5678;
    #1;
    check("wr_p1_ready",    {31'b0, p1_req_ready}, 32'd1);
    check("wr_p0_ready",    {31'b0, p0_req_ready}, 32'd0);
    check("wr_mem_wren",    {31'b0, mem_wren}, 32'd1);
    check("wr_mem_wr_addr", mem_wr_addr, 32'h20);
    check("wr_mem_wr_data", mem_wr_data, 32'h1234_5678);
    check("wr_mem_rd_addr", mem_rd_addr, 32'h0);
    tick();
    idle_inputs();
    p0_req_valid = 1'b1; p0_req_addr = 32'h20;
    #1;
    check("wr_p1_resp_valid", {31'b0, p1_resp_valid}, 32'd1);
    check("wr_p1_resp_rdata", p1_resp_rdata, 32'h0);
    check("raw_p0_ready",     {31'b0, p0_req_ready}, 32'd1);
    check("raw_mem_rd_addr",  mem_rd_addr, 32'h20);
    check("raw_mem_wren",     {31'b0, mem_wren}, 32'd0);
    tick();
    p0_req_valid = 1'b0;
    #1;
    check("raw_p0_resp_valid", {31'b0, p0_resp_valid}, 32'd1);
    check("raw_p0_resp_rdata", p0_resp_rdata, 32'h1234_5678);

    // Four-cycle conflict starting from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p0_req_valid = 1'b1; p0_req_addr = 32'h10;
    p1_req_valid = 1'b1; p1_req_addr = 32'h20;
`ifdef MEM_ARB_FIXED_PRIO_EN
    exp_port = '{1, 1, 1, 1};
`else
    exp_port = '{0, 1, 0, 1};
`endif
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cf%0d_p0_ready", i), {31'b0, p0_req_ready}, (exp_port[i] == 0) ? 32'd1 : 32'd0);
      check($sformatf("cf%0d_p1_ready", i), {31'b0, p1_req_ready}, (exp_port[i] == 1) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("cf%0d_p0_resp_valid", i), {31'b0, p0_resp_valid}, (exp_port[i] == 0) ? 32'd1 : 32'd0);
      check($sformatf("cf%0d_p1_resp_valid", i), {31'b0, p1_resp_valid}, (exp_port[i] == 1) ? 32'd1 : 32'd0);
      check($sformatf("cf%0d_rdata", i), p0_resp_rdata | p1_resp_rdata,
            (exp_port[i] == 0) ? 32'hDEAD_BEEF : 32'h1234_5678);
      check($sformatf("cf%0d_busy", i), {31'b0, busy}, 32'd1);
    end
    p1_req_valid = 1'b0;
    #1;
    check("cf4_p0_ready", {31'b0, p0_req_ready}, 32'd1);
    tick();
    p0_req_valid = 1'b0;
    #1;
    check("cf4_p0_resp_valid", {31'b0, p0_resp_valid}, 32'd1);

    // Reset while a response is outstanding
    tick();
    p0_req_valid = 1'b1; p0_req_addr = 32'h10;
    #1;
    check("rm_p0_ready", {31'b0, p0_req_ready}, 32'd1);
    tick();
    p0_req_valid = 1'b0;
    rst = 1'b1;
    p1_req_valid = 1'b1; p1_req_addr = 32'h20;
    #1;
    check("rm_p0_resp_valid", {31'b0, p0_resp_valid}, 32'd0);
    check("rm_busy",          {31'b0, busy}, 32'd0);
    check("rm_p1_ready_in_rst", {31'b0, p1_req_ready}, 32'd0);
    tick();
    check("rm_p0_resp_after", {31'b0, p0_resp_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("rm_p1_ready", {31'b0, p1_req_ready}, 32'd1);
    tick();
    p1_req_valid = 1'b0;
    #1;
    check("rm_p1_resp_valid", {31'b0, p1_resp_valid}, 32'd1);
    check("rm_p1_resp_rdata", p1_resp_rdata, 32'h1234_5678);

    // Idle cycles
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle%0d_wren", i),  {31'b0, mem_wren}, 32'd0);
      check($sformatf("idle%0d_ready", i), {30'b0, p1_req_ready, p0_req_ready}, 32'd0);
      check($sformatf("idle%0d_resp", i),  {30'b0, p1_resp_valid, p0_resp_valid}, 32'd0);
      check($sformatf("idle%0d_busy", i),  {31'b0, busy}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
